// File: rtl/cpu_types_pkg.sv
// Shared types for the single-cycle datapath: machine word and request FSM states.
package cpu_types_pkg;

  localparam int WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    DATA   = 2'd1,
    HALTED = 2'd2
  } req_state_t;

endpackage

// File: rtl/request_unit_if.sv
// Bundle of the request_unit signals for benches that prefer an interface handle.
interface request_unit_if #(
  parameter int CNT_W = cpu_types_pkg::WORD_W
) (
  input logic CLK
);
  logic             RST;
  logic             ihit;
  logic             dhit;
  logic             MemRd;
  logic             MemWr;
  logic             Halt;
  logic             imemREN;
  logic             dmemREN;
  logic             dmemWEN;
  logic             pcEN;
  logic             halted;
  logic [CNT_W-1:0] instr_cnt;
  logic [CNT_W-1:0] stall_cnt;

  modport ru (
    input  CLK, RST, ihit, dhit, MemRd, MemWr, Halt,
    output imemREN, dmemREN, dmemWEN, pcEN, halted, instr_cnt, stall_cnt
  );

  modport tb (
    input  CLK, imemREN, dmemREN, dmemWEN, pcEN, halted, instr_cnt, stall_cnt,
    output RST, ihit, dhit, MemRd, MemWr, Halt
  );
endinterface

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping; async active-high clear.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         en_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (en_i && (cnt_q != {W{1'b1}})) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/request_unit.sv
// Memory-request sequencer: fetch / data / halted FSM driving I/D request lines,
// the PC commit strobe, a sticky halt flag, and retired/stall counters.
module request_unit
  import cpu_types_pkg::*;
#(
  parameter int CNT_W = WORD_W
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic             MemRd,
  input  logic             MemWr,
  input  logic             Halt,
  output logic             imemREN,
  output logic             dmemREN,
  output logic             dmemWEN,
  output logic             pcEN,
  output logic             halted,
  output logic [CNT_W-1:0] instr_cnt,
  output logic [CNT_W-1:0] stall_cnt
);

  req_state_t state_q, state_d;
  logic       dren_q, dren_d;
  logic       dwen_q, dwen_d;
  logic       halted_q, halted_d;
  logic       imem_c, pc_c, inc_instr, inc_stall;

  always_comb begin
    state_d   = state_q;
    dren_d    = dren_q;
    dwen_d    = dwen_q;
    imem_c    = 1'b0;
    pc_c      = 1'b0;
    inc_instr = 1'b0;
    inc_stall = 1'b0;
    case (state_q)
      FETCH: begin
        imem_c = 1'b1;
        if (!ihit) begin
          inc_stall = 1'b1;
        end else if (Halt) begin
          inc_instr = 1'b1;
          state_d   = HALTED;
        end else if (MemRd || MemWr) begin
          // store wins when the decoder flags both
          dwen_d  = MemWr;
          dren_d  = MemRd & ~MemWr;
          state_d = DATA;
        end else begin
          pc_c      = 1'b1;
          inc_instr = 1'b1;
        end
      end
      DATA: begin
        imem_c = 1'b1;
        if (!dhit) begin
          inc_stall = 1'b1;
        end else begin
          pc_c      = 1'b1;
          inc_instr = 1'b1;
          dren_d    = 1'b0;
          dwen_d    = 1'b0;
          state_d   = FETCH;
        end
      end
      HALTED: begin
        dren_d = 1'b0;
        dwen_d = 1'b0;
      end
      default: begin
        state_d = FETCH;
        dren_d  = 1'b0;
        dwen_d  = 1'b0;
      end
    endcase
    halted_d = (state_d == HALTED);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= FETCH;
      dren_q   <= 1'b0;
      dwen_q   <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      dren_q   <= dren_d;
      dwen_q   <= dwen_d;
      halted_q <= halted_d;
    end
  end

  // Combinational strobes are gated so nothing is requested while reset is held.
  assign imemREN = imem_c & ~RST;
  assign pcEN    = pc_c & ~RST;
  assign dmemREN = dren_q;
  assign dmemWEN = dwen_q;
  assign halted  = halted_q;

  sat_counter #(.W(CNT_W)) u_instr_cnt (
    .CLK   (CLK),
    .RST   (RST),
    .en_i  (inc_instr),
    .cnt_o (instr_cnt)
  );

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .CLK   (CLK),
    .RST   (RST),
    .en_i  (inc_stall),
    .cnt_o (stall_cnt)
  );

endmodule

// File: tb/tb_request_unit.sv
// Directed bench for request_unit: vector table for the main flow plus
// hand sequences for halt, reset recovery, saturation and async reset mid-DATA.
module tb_request_unit;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // 32-bit DUT
  logic        rst, ihit, dhit, rd, wr, hlt;
  logic        imem, dren, dwen, pc, halted;
  logic [31:0] icnt, scnt;

  request_unit #(.CNT_W(32)) dut (
    .CLK(clk), .RST(rst), .ihit(ihit), .dhit(dhit), .MemRd(rd), .MemWr(wr), .Halt(hlt),
    .imemREN(imem), .dmemREN(dren), .dmemWEN(dwen), .pcEN(pc), .halted(halted),
    .instr_cnt(icnt), .stall_cnt(scnt)
  );

  // 3-bit counter DUT for saturation and async reset checks
  logic        s_rst, s_ihit, s_dhit, s_rd, s_wr, s_hlt;
  logic        s_imem, s_dren, s_dwen, s_pc, s_halted;
  logic [2:0]  s_icnt, s_scnt;

  request_unit #(.CNT_W(3)) dut_s (
    .CLK(clk), .RST(s_rst), .ihit(s_ihit), .dhit(s_dhit), .MemRd(s_rd), .MemWr(s_wr),
    .Halt(s_hlt), .imemREN(s_imem), .dmemREN(s_dren), .dmemWEN(s_dwen), .pcEN(s_pc),
    .halted(s_halted), .instr_cnt(s_icnt), .stall_cnt(s_scnt)
  );

  typedef struct {
    logic        ihit, dhit, rd, wr, hlt;
    logic        imem, dren, dwen, pc, halted;
    logic [31:0] ic, sc;
  } vec_t;

  vec_t vecs[16];
  int   n_chk = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_outs(input string tag, input logic e_imem, input logic e_dren,
                          input logic e_dwen, input logic e_pc, input logic e_halted,
                          input logic [31:0] e_ic, input logic [31:0] e_sc);
    chk({tag, ".imemREN"},   {31'd0, imem},   {31'd0, e_imem});
    chk({tag, ".dmemREN"},   {31'd0, dren},   {31'd0, e_dren});
    chk({tag, ".dmemWEN"},   {31'd0, dwen},   {31'd0, e_dwen});
    chk({tag, ".pcEN"},      {31'd0, pc},     {31'd0, e_pc});
    chk({tag, ".halted"},    {31'd0, halted}, {31'd0, e_halted});
    chk({tag, ".instr_cnt"}, icnt, e_ic);
    chk({tag, ".stall_cnt"}, scnt, e_sc);
  endtask

  task automatic drive(input logic i, input logic d, input logic r, input logic w, input logic h);
    ihit = i; dhit = d; rd = r; wr = w; hlt = h;
  endtask

  task automatic s_drive(input logic i, input logic d, input logic r, input logic w, input logic h);
    s_ihit = i; s_dhit = d; s_rd = r; s_wr = w; s_hlt = h;
  endtask

  initial begin
    //                ihit dhit rd wr hlt | imem dren dwen pc halt | ic sc
    vecs[0]  = '{1,0,0,0,0, 1,0,0,1,0, 0,0};  // ALU
    vecs[1]  = '{1,0,0,0,0, 1,0,0,1,0, 1,0};  // ALU
    vecs[2]  = '{1,0,0,0,0, 1,0,0,1,0, 2,0};  // ALU
    vecs[3]  = '{1,0,1,0,0, 1,0,0,0,0, 3,0};  // load issued
    vecs[4]  = '{0,0,0,0,0, 1,1,0,0,0, 3,0};  // waiting dhit
    vecs[5]  = '{0,0,0,0,0, 1,1,0,0,0, 3,1};
    vecs[6]  = '{0,0,0,0,0, 1,1,0,0,0, 3,2};
    vecs[7]  = '{0,0,0,0,0, 1,1,0,0,0, 3,3};
    vecs[8]  = '{0,1,0,0,0, 1,1,0,1,0, 3,4};  // load commits
    vecs[9]  = '{0,1,0,0,0, 1,0,0,0,0, 4,4};  // spurious dhit in FETCH
    vecs[10] = '{1,0,1,1,0, 1,0,0,0,0, 4,5};  // rd+wr -> store
    vecs[11] = '{1,0,0,0,0, 1,0,1,0,0, 4,5};  // ihit in DATA ignored
    vecs[12] = '{0,1,0,0,0, 1,0,1,1,0, 4,6};  // store commits
    vecs[13] = '{1,0,1,0,1, 1,0,0,0,0, 5,6};  // halt beats MemRd
    vecs[14] = '{1,1,1,1,0, 0,0,0,0,1, 6,6};  // halted
    vecs[15] = '{1,1,0,0,1, 0,0,0,0,1, 6,6};

    rst = 1'b1; drive(1, 0, 0, 0, 0);
    s_rst = 1'b1; s_drive(0, 0, 0, 0, 0);

    // reset held with ihit high: everything quiet
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    chk_outs("reset", 0, 0, 0, 0, 0, 0, 0);

    // release mid-cycle, inputs idle, sampled before any edge
    rst = 1'b0; drive(0, 0, 0, 0, 0); #1;
    chk_outs("release", 1, 0, 0, 0, 0, 0, 0);

    for (int k = 0; k < 16; k++) begin
      drive(vecs[k].ihit, vecs[k].dhit, vecs[k].rd, vecs[k].wr, vecs[k].hlt);
      #1;
      chk_outs($sformatf("vec%0d", k), vecs[k].imem, vecs[k].dren, vecs[k].dwen,
               vecs[k].pc, vecs[k].halted, vecs[k].ic, vecs[k].sc);
      @(posedge clk); @(negedge clk);
    end

    // halted ignores everything for 10 more cycles
    for (int k = 0; k < 10; k++) begin
      drive(1, 1, k[0], k[1], k[2]); #1;
      chk_outs($sformatf("halt_hold%0d", k), 0, 0, 0, 0, 1, 6, 6);
      @(posedge clk); @(negedge clk);
    end

    // reset recovers to FETCH
    rst = 1'b1; drive(1, 0, 0, 0, 0); #1;
    chk_outs("halt_rst", 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk); @(negedge clk);
    rst = 1'b0; #1;
    chk_outs("post_halt_alu", 1, 0, 0, 1, 0, 0, 0);
    @(posedge clk); @(negedge clk);
    drive(0, 0, 0, 0, 0); #1;
    chk_outs("post_halt_cnt", 1, 0, 0, 0, 0, 1, 0);

    // CNT_W=3: nine ALU ops saturate instr_cnt at 7
    s_rst = 1'b0; s_drive(1, 0, 0, 0, 0);
    repeat (9) begin
      @(posedge clk); @(negedge clk);
    end
    #1;
    chk("sat.instr_cnt", {29'd0, s_icnt}, 32'd7);
    chk("sat.stall_cnt", {29'd0, s_scnt}, 32'd0);

    // store, then async reset mid-DATA
    s_drive(1, 0, 0, 1, 0);
    @(posedge clk); @(negedge clk);
    s_drive(0, 0, 0, 0, 0); #1;
    chk("midrst.dwen_before", {31'd0, s_dwen}, 32'd1);
    chk("midrst.pc_before",   {31'd0, s_pc},   32'd0);
    @(posedge clk); #2;
    chk("midrst.stall_before", {29'd0, s_scnt}, 32'd1);
    s_rst = 1'b1; #1;
    chk("midrst.dwen_async", {31'd0, s_dwen}, 32'd0);
    chk("midrst.imem_async", {31'd0, s_imem}, 32'd0);
    chk("midrst.icnt_async", {29'd0, s_icnt}, 32'd0);
    chk("midrst.scnt_async", {29'd0, s_scnt}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
